// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT valid/ready output (1-cycle fill latency), drops bytes when full (sticky overflow), err counter.
// Optional idle-data timeout interrupt enabled by defining RX_TIMEOUT_EN; otherwise timeout_irq is tied low.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int THRESH      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_error,
  input  logic                     flush,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     level_irq,
  output logic                     overflow,
  output logic [7:0]               err_count,
  input  logic                     stat_clr,
  output logic                     timeout_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ThreshC = (AW+1)'(THRESH);

  if (DEPTH < 2 || (1 << AW) != DEPTH || THRESH < 1 || THRESH > DEPTH || TIMEOUT_CYC < 1)
  begin : g_bad_params
    $error("uart_rx_fifo: illegal parameter combination");
  end

  logic [DATA_W:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W:0]  head;
  logic             push, pop, ovf_evt, err_evt;

  assign empty     = (count == '0);
  assign full      = (count == DepthC);
  assign level_irq = (count >= ThreshC);
  assign m_valid   = !empty;
  assign pop       = m_valid && m_ready;
  assign push      = rx_valid && (!full || pop);
  assign ovf_evt   = rx_valid && full && !pop && !flush;
  assign err_evt   = rx_valid && rx_error;

  // Gate the head with m_valid so stale RAM never leaks out when empty.
  assign head   = mem[rd_ptr];
  assign m_data = m_valid ? head[DATA_W-1:0] : '0;
  assign m_err  = m_valid ? head[DATA_W]     : 1'b0;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {rx_error, rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A set/increment in the same cycle as stat_clr takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (ovf_evt)       overflow <= 1'b1;
      else if (stat_clr) overflow <= 1'b0;

      if (err_evt) begin
        if (stat_clr)                err_count <= 8'd1;
        else if (err_count != 8'hFF) err_count <= err_count + 1'b1;
      end else if (stat_clr) begin
        err_count <= '0;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IdleMax = IW'(TIMEOUT_CYC);
  logic [IW-1:0] idle;

  always_ff @(posedge clk) begin
    if (rst || flush || push || pop)       idle <= '0;
    else if (!empty && idle != IdleMax)    idle <= idle + 1'b1;
  end

  assign timeout_irq = (idle == IdleMax) && !empty;
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue of expected {err,data} entries plus flag/counter models.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TCYC  = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error, flush, m_ready, stat_clr;
  logic [7:0] m_data;
  logic       m_err, m_valid, full, empty, level_irq, overflow, timeout_irq;
  logic [4:0] count;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .THRESH(8), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .flush(flush), .m_data(m_data), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .full(full), .empty(empty), .level_irq(level_irq), .overflow(overflow),
    .err_count(err_count), .stat_clr(stat_clr), .timeout_irq(timeout_irq)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];
  logic       m_ovf;
  int         m_errc;
  int         m_idle;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, score any pop, advance the models, then check state after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic e, input logic r,
                     input logic f, input logic s);
    int  sz;
    bit  mpop, mpush;
    rx_valid = v; rx_data = d; rx_error = e; m_ready = r; flush = f; stat_clr = s;
    @(negedge clk);
    sz   = exp_q.size();
    mpop = r && (sz != 0);
    check("m_valid_pre", 32'(m_valid), 32'(sz != 0));
    if (mpop) check("head", 32'({m_err, m_data}), 32'(exp_q[0]));
    mpush = v && (sz < DEPTH || mpop);
    if (f) begin
      exp_q.delete();
    end else begin
      if (mpop)  void'(exp_q.pop_front());
      if (mpush) exp_q.push_back({e, d});
    end
    if (v && !f && sz == DEPTH && !mpop) m_ovf = 1'b1;
    else if (s)                          m_ovf = 1'b0;
    if (v && e) m_errc = s ? 1 : (m_errc < 255 ? m_errc + 1 : 255);
    else if (s) m_errc = 0;
    if (f || mpush || mpop)           m_idle = 0;
    else if (sz != 0 && m_idle < TCYC) m_idle++;
    @(posedge clk); #1;
    check("count",    32'(count),     32'(exp_q.size()));
    check("full",     32'(full),      32'(exp_q.size() == DEPTH));
    check("empty",    32'(empty),     32'(exp_q.size() == 0));
    check("level",    32'(level_irq), 32'(exp_q.size() >= 8));
    check("m_valid",  32'(m_valid),   32'(exp_q.size() != 0));
    check("overflow", 32'(overflow),  32'(m_ovf));
    check("err_cnt",  32'(err_count), 32'(m_errc));
`ifdef RX_TIMEOUT_EN
    check("timeout",  32'(timeout_irq), 32'(m_idle == TCYC && exp_q.size() != 0));
`else
    check("timeout",  32'(timeout_irq), 32'd0);
`endif
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 0; rx_data = 0; rx_error = 0; flush = 0; m_ready = 0; stat_clr = 0;
    m_ovf = 0; m_errc = 0; m_idle = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'({m_err, m_data}), 32'd0);
    check("rst_flags", 32'({level_irq, overflow, timeout_irq}), 32'd0);
    check("rst_errc",  32'(err_count), 32'd0);

    // First-word fall-through latency
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwft_data", 32'({m_err, m_data}), 32'h0A5);
    drain(2);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    drain(DEPTH + 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Push while full with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_pp_cnt", 32'(count), 32'd16);
    drain(DEPTH + 1);

    // Error entries, then stat_clr racing an error push
    repeat (3) cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    check("errc3", 32'(err_count), 32'd3);
    cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    check("errc_clr_race", 32'(err_count), 32'd1);
    drain(5);

    // Flush with concurrent push
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_empty", 32'(empty), 32'd1);
    drain(3);

    // Idle timeout (or tied-low when feature disabled)
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TCYC + 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
